fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage feeding the decoder. It holds the program counter, issues one outstanding request at a time to instruction memory, and captures the returned word into the IF/ID pipeline register (`if_pc_o`, `if_instr_o`, `if_valid_o`). It accepts redirects from the decoder (statically predicted JAL/branch/JALR-x0 targets) and from execute (JALR mispredicts), and holds the pipeline on stall.

## Interface
Parameters:
- `ADDRESS_BITS`, 32: PC and memory address width.
- `BOOT_ADDR`, 0: PC loaded on reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `imem_req`  out  1  request valid. Registered.
- `imem_addr`  out  ADDRESS_BITS  request address. Word aligned.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response data valid; at least 1 cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `dec_redirect_i`  in  1  decoder redirect, from decoder `pc_s_d`.
- `dec_target_i`  in  ADDRESS_BITS  decoder target, from decoder `target_pc`.
- `ex_redirect_i`  in  1  execute redirect for a JALR mispredict.
- `ex_target_i`  in  ADDRESS_BITS  execute target.
- `stall_i`  in  1  ID holds its instruction (hazard or encryption loop).
- `if_pc_o`  out  ADDRESS_BITS  PC of the instruction in IF/ID.
- `if_instr_o`  out  32  instruction in IF/ID.
- `if_valid_o`  out  1  IF/ID holds a live instruction.

## Operation
- State machine with three states.
  - IDLE: no request. Go to REQ when no request is blocked.
  - REQ: `imem_req`=1 with `imem_addr`=`fetch_pc`. On `imem_gnt`: `addr_q`←`fetch_pc`, `fetch_pc`←`fetch_pc`+4 (wraps modulo 2^ADDRESS_BITS), go to WAIT.
  - WAIT: on `imem_rvalid`, deliver the word, then go to REQ, or to IDLE if blocked.
- A request is blocked when `hold_valid`=1. `hold_valid`: the response arrived while `if_valid_o`=1 and `stall_i`=1, so the word sits in a one-entry hold buffer.
- Delivery when not stalled: IF/ID←{`addr_q`, `imem_rdata`, valid=1}.
- Hold buffer moves into IF/ID on the first cycle with `stall_i`=0.
- IF/ID update when `stall_i`=0 and nothing is delivered: `if_valid_o`←0.
- Redirect priority: `ex_redirect_i` > `dec_redirect_i` > sequential.
- `ex_redirect_i`=1 is honoured regardless of `stall_i`:
  - `fetch_pc`←`ex_target_i`.
  - `if_valid_o`←0, `hold_valid`←0.
  - If in REQ or WAIT, set `kill_q`.
- `dec_redirect_i` is honoured only when `if_valid_o`=1 and `stall_i`=0:
  - `fetch_pc`←`dec_target_i`.
  - The IF/ID instruction (the jump itself) advances normally.
  - Any hold-buffer entry is discarded; any in-flight transaction sets `kill_q`.
- Killed transaction:
  - A request already presented in REQ completes its handshake.
  - Its response is dropped (no delivery) and `kill_q` clears.
  - The next request uses the redirected `fetch_pc`.
- Redirect targets have bits [1:0] forced to 00.
- A redirect and `imem_rvalid` in the same cycle: the response is killed.

## Timing
- Reset values:
  - `imem_req`=0, `if_valid_o`=0, `if_pc_o`=0, `if_instr_o`=0.
  - `fetch_pc`=BOOT_ADDR, `kill_q`=0, `hold_valid`=0, state IDLE.
- First cycle after reset release: IDLE→REQ. `imem_req` is asserted on the following cycle.
- With zero-wait memory (grant in the request cycle, rvalid the next cycle), throughput is 1 instruction per 2 cycles.
- Latency is 1 cycle from the rvalid edge to `if_valid_o`.
- Address hold: `imem_addr` is stable while `imem_req`=1 and `imem_gnt`=0.
- One transaction outstanding at most.
- `rst` asserted mid-transaction returns to reset state next edge; a later stray `imem_rvalid` in IDLE is ignored.

## Structure
- Shared package `fetch_pkg` holds:
  - state encoding localparams (IDLE, REQ, WAIT);
  - default BOOT_ADDR;
  - instruction width 32.
- Single module; no sub-module.
- The hold buffer and the IF/ID register are plain registers in the same file.

## Test plan
- Reset then zero-wait memory returning NOPs (32'h00000013).
  - Required: requests to 0x0, 0x4, 0x8.
  - `if_valid_o` pulses every 2nd cycle with `if_pc_o`=0x0, 0x4, 0x8.
- Memory delays `imem_gnt` 3 cycles on 0x4.
  - Required: `imem_addr` holds 0x4 throughout.
  - No duplicate fetch.
- `stall_i`=1 for 5 cycles with the 0x8 response arriving during the stall.
  - Required: `if_pc_o` stays 0x4.
  - 0x8 is held with no new request issued.
  - 0x8 appears on the cycle after stall release.
- `dec_redirect_i`=1, target 0x100, while the 0xC fetch is in WAIT.
  - Required: 0xC response dropped.
  - Next request is 0x100; next `if_pc_o` is 0x100.
- `ex_redirect_i`=1, target 0x203, together with `dec_redirect_i`=1 target 0x300 and `stall_i`=1.
  - Required: `if_valid_o`=0 next cycle.
  - Next request is 0x200.
- `rst` pulsed while in WAIT, with `imem_rvalid` arriving 1 cycle later.
  - Required: response ignored.
  - Fetch restarts at BOOT_ADDR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// instruction width and the default boot address.
package fetch_pkg;

  localparam int unsigned INSTR_BITS        = 32;
  localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, one-entry
// hold buffer for responses that land during a stall, and the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned              ADDRESS_BITS = 32,
  parameter logic [ADDRESS_BITS-1:0]  BOOT_ADDR    = ADDRESS_BITS'(DEFAULT_BOOT_ADDR)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  input  logic                    imem_gnt,
  input  logic                    imem_rvalid,
  input  logic [INSTR_BITS-1:0]   imem_rdata,
  input  logic                    dec_redirect_i,
  input  logic [ADDRESS_BITS-1:0] dec_target_i,
  input  logic                    ex_redirect_i,
  input  logic [ADDRESS_BITS-1:0] ex_target_i,
  input  logic                    stall_i,
  output logic [ADDRESS_BITS-1:0] if_pc_o,
  output logic [INSTR_BITS-1:0]   if_instr_o,
  output logic                    if_valid_o
);

  localparam logic [ADDRESS_BITS-1:0] PC_STEP    = ADDRESS_BITS'(32'd4);
  localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~ADDRESS_BITS'(32'd3);

  function automatic logic [ADDRESS_BITS-1:0] align_word(input logic [ADDRESS_BITS-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

  fetch_state_e            state_r, state_s;
  logic [ADDRESS_BITS-1:0] fetch_pc_r, fetch_pc_s;
  logic [ADDRESS_BITS-1:0] imem_addr_r, addr_q_r, hold_pc_r, if_pc_r;
  logic [INSTR_BITS-1:0]   hold_instr_r, if_instr_r;
  logic                    imem_req_r, if_valid_r;
  logic                    hold_valid_r, hold_valid_s;
  logic                    kill_r, kill_s;
  logic                    dec_take_s, redirect_s, resp_s, deliver_s, hold_load_s;

  // Redirect arbitration and response classification for this cycle.
  always_comb begin
    dec_take_s  = dec_redirect_i & if_valid_r & ~stall_i & ~ex_redirect_i;
    redirect_s  = ex_redirect_i | dec_take_s;
    resp_s      = (state_r == S_WAIT) & imem_rvalid;
    deliver_s   = resp_s & ~kill_r & ~redirect_s;
    hold_load_s = deliver_s & if_valid_r & stall_i;
  end

  // Next PC, hold-buffer occupancy, kill flag and FSM transition.
  always_comb begin
    fetch_pc_s   = fetch_pc_r;
    hold_valid_s = hold_valid_r;
    kill_s       = kill_r;
    state_s      = state_r;

    // A killed grant must not advance past the redirect target.
    if (ex_redirect_i) begin
      fetch_pc_s = align_word(ex_target_i);
    end else if (dec_take_s) begin
      fetch_pc_s = align_word(dec_target_i);
    end else if ((state_r == S_REQ) && imem_gnt && !kill_r) begin
      fetch_pc_s = fetch_pc_r + PC_STEP;
    end else begin
      fetch_pc_s = fetch_pc_r;
    end

    if (redirect_s || !stall_i) begin
      hold_valid_s = 1'b0;
    end else if (hold_load_s) begin
      hold_valid_s = 1'b1;
    end else begin
      hold_valid_s = hold_valid_r;
    end

    if (resp_s) begin
      kill_s = 1'b0;
    end else if (redirect_s && (state_r != S_IDLE)) begin
      kill_s = 1'b1;
    end else begin
      kill_s = kill_r;
    end

    case (state_r)
      S_IDLE:  state_s = hold_valid_s ? S_IDLE : S_REQ;
      S_REQ:   state_s = imem_gnt ? S_WAIT : S_REQ;
      S_WAIT: begin
        if (resp_s) begin
          state_s = hold_valid_s ? S_IDLE : S_REQ;
        end else begin
          state_s = S_WAIT;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Control state and the registered imem request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      fetch_pc_r   <= BOOT_ADDR;
      kill_r       <= 1'b0;
      hold_valid_r <= 1'b0;
      imem_req_r   <= 1'b0;
      imem_addr_r  <= BOOT_ADDR;
      addr_q_r     <= '0;
    end else begin
      state_r      <= state_s;
      fetch_pc_r   <= fetch_pc_s;
      kill_r       <= kill_s;
      hold_valid_r <= hold_valid_s;
      imem_req_r   <= (state_s == S_REQ);
      // Address is latched on entry to REQ and held until granted.
      if ((state_s == S_REQ) && (state_r != S_REQ)) begin
        imem_addr_r <= fetch_pc_s;
      end
      if ((state_r == S_REQ) && imem_gnt) begin
        addr_q_r <= imem_addr_r;
      end
    end
  end

  // Hold buffer and IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_pc_r    <= '0;
      hold_instr_r <= '0;
      if_pc_r      <= '0;
      if_instr_r   <= '0;
      if_valid_r   <= 1'b0;
    end else begin
      if (hold_load_s) begin
        hold_pc_r    <= addr_q_r;
        hold_instr_r <= imem_rdata;
      end
      if (ex_redirect_i) begin
        if_valid_r <= 1'b0;
      end else if (!stall_i) begin
        if (hold_valid_r && !dec_take_s) begin
          if_pc_r    <= hold_pc_r;
          if_instr_r <= hold_instr_r;
          if_valid_r <= 1'b1;
        end else if (deliver_s) begin
          if_pc_r    <= addr_q_r;
          if_instr_r <= imem_rdata;
          if_valid_r <= 1'b1;
        end else begin
          if_valid_r <= 1'b0;
        end
      end else if (deliver_s && !if_valid_r) begin
        // An empty IF/ID slot can take a word even while ID is stalled.
        if_pc_r    <= addr_q_r;
        if_instr_r <= imem_rdata;
        if_valid_r <= 1'b1;
      end
    end
  end

  assign imem_req   = imem_req_r;
  assign imem_addr  = imem_addr_r;
  assign if_pc_o    = if_pc_r;
  assign if_instr_o = if_instr_r;
  assign if_valid_o = if_valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle-by-cycle stimulus with hand-derived
// expectations for sequential fetch, grant wait, stall hold, redirects, reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_redirect_i;
  logic [31:0] dec_target_i;
  logic        ex_redirect_i;
  logic [31:0] ex_target_i;
  logic        stall_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_valid_o;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] W_00 = 32'h0010_0093;
  localparam logic [31:0] W_04 = 32'h0020_0113;
  localparam logic [31:0] W_08 = 32'h0030_0193;
  localparam logic [31:0] W_0C = 32'h0040_0213;
  localparam logic [31:0] W_100 = 32'h0050_0293;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  localparam logic [31:0] W_BOOT = 32'h0060_0313;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .dec_redirect_i (dec_redirect_i),
    .dec_target_i   (dec_target_i),
    .ex_redirect_i  (ex_redirect_i),
    .ex_target_i    (ex_target_i),
    .stall_i        (stall_i),
    .if_pc_o        (if_pc_o),
    .if_instr_o     (if_instr_o),
    .if_valid_o     (if_valid_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic r, input logic g, input logic v, input logic [31:0] d,
                     input logic s, input logic dr, input logic [31:0] dt,
                     input logic er, input logic [31:0] et);
    rst            = r;
    imem_gnt       = g;
    imem_rvalid    = v;
    imem_rdata     = d;
    stall_i        = s;
    dec_redirect_i = dr;
    dec_target_i   = dt;
    ex_redirect_i  = er;
    ex_target_i    = et;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("rst_req", {31'd0, imem_req}, 32'd0);
    check_val("rst_valid", {31'd0, if_valid_o}, 32'd0);
    check_val("rst_pc", if_pc_o, 32'h0);
    check_val("rst_instr", if_instr_o, 32'h0);

    // Zero-wait sequential fetch of NOPs
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("first_req", {31'd0, imem_req}, 32'd1);
    check_val("first_addr", imem_addr, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("req_drop_wait", {31'd0, imem_req}, 32'd0);
    check_val("valid_c2", {31'd0, if_valid_o}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, NOP, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("valid_c3", {31'd0, if_valid_o}, 32'd1);
    check_val("pc_0", if_pc_o, 32'h0);
    check_val("instr_0", if_instr_o, NOP);
    check_val("addr_4", imem_addr, 32'h4);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("valid_c4", {31'd0, if_valid_o}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, NOP, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("valid_c5", {31'd0, if_valid_o}, 32'd1);
    check_val("pc_4", if_pc_o, 32'h4);
    check_val("addr_8", imem_addr, 32'h8);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("valid_c6", {31'd0, if_valid_o}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, NOP, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("valid_c7", {31'd0, if_valid_o}, 32'd1);
    check_val("pc_8", if_pc_o, 32'h8);
    check_val("addr_c", imem_addr, 32'hC);

    // Reset while a request is pending, then restart
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("rst2_req", {31'd0, imem_req}, 32'd0);
    check_val("rst2_valid", {31'd0, if_valid_o}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, W_00, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("b_pc_0", if_pc_o, 32'h0);
    check_val("b_instr_0", if_instr_o, W_00);

    // Grant withheld 3 cycles on 0x4
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_val("gnt_wait_req", {31'd0, imem_req}, 32'd1);
      check_val("gnt_wait_addr", imem_addr, 32'h4);
    end
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("no_dup_req", {31'd0, imem_req}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, W_04, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("b_pc_4", if_pc_o, 32'h4);
    check_val("b_instr_4", if_instr_o, W_04);
    check_val("addr_8_b", imem_addr, 32'h8);

    // Five-cycle stall; the 0x8 response lands in the hold buffer
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, W_08, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("stall_pc", if_pc_o, 32'h4);
    check_val("stall_valid", {31'd0, if_valid_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      check_val("stall_no_req", {31'd0, imem_req}, 32'd0);
      check_val("stall_pc_hold", if_pc_o, 32'h4);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("release_pc", if_pc_o, 32'h8);
    check_val("release_instr", if_instr_o, W_08);
    check_val("release_req", {31'd0, imem_req}, 32'd1);
    check_val("release_addr", imem_addr, 32'hC);

    // Decoder redirect to 0x100 while 0xC is in WAIT
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("pre_dec_pc", if_pc_o, 32'h8);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    check_val("dec_advance", {31'd0, if_valid_o}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, W_0C, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("dec_drop", {31'd0, if_valid_o}, 32'd0);
    check_val("dec_req", {31'd0, imem_req}, 32'd1);
    check_val("dec_addr", imem_addr, 32'h100);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, W_100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("dec_pc", if_pc_o, 32'h100);
    check_val("dec_instr", if_instr_o, W_100);
    check_val("addr_104", imem_addr, 32'h104);

    // Execute redirect beats decoder redirect and stall; target is aligned
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h203);
    check_val("ex_valid", {31'd0, if_valid_o}, 32'd0);
    check_val("ex_addr_hold", imem_addr, 32'h104);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, JUNK, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("ex_drop", {31'd0, if_valid_o}, 32'd0);
    check_val("ex_addr", imem_addr, 32'h200);

    // Reset in WAIT, stray rvalid one cycle later
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("rst3_req", {31'd0, imem_req}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, JUNK, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("stray_valid", {31'd0, if_valid_o}, 32'd0);
    check_val("boot_addr", imem_addr, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, W_BOOT, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("boot_valid", {31'd0, if_valid_o}, 32'd1);
    check_val("boot_pc", if_pc_o, 32'h0);
    check_val("boot_instr", if_instr_o, W_BOOT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
